phy_reset_ctrl: RTL and testbench

- Output-side companion to the input conditioning used at FPGA top level (PLL-locked reset sync, switch debounce).
- Generates a timed, re-triggerable active-low reset sequence for one external RGMII PHY (drives `*_RST_N`).
- Holds the MAC/core domain in reset until the PHY has settled.
- Synchronises and latches the PHY's asynchronous `INT_N` into a sticky, acknowledgeable flag. One instance per PHY.

---
 rtl/phy_reset_ctrl_pkg.sv | 38 +++
 rtl/phy_reset_ctrl_sync.sv | 36 +++
 rtl/phy_reset_ctrl.sv | 162 ++++++++++++++++
 tb/tb_phy_reset_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_reset_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : phy_reset_ctrl_pkg
//  Description : Shared definitions for the PHY reset controller: sequencer
//                state encodings, the registered output bundle and the
//                state-to-output decode.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package phy_reset_ctrl_pkg;

   // Sequencer states
   localparam logic [1:0] ST_ASSERT = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_RUN    = 2'd2;

   // Outputs that depend only on the sequencer state
   typedef struct packed {
      logic phy_reset_n;
      logic mac_rst;
      logic ready;
   } seq_out_t;

   localparam seq_out_t SEQ_OUT_RESET = '{phy_reset_n: 1'b0, mac_rst: 1'b1, ready: 1'b0};

   function automatic seq_out_t state_outputs(input logic [1:0] st);
      seq_out_t o;
      o = SEQ_OUT_RESET;
      case (st)
         ST_SETTLE: o = '{phy_reset_n: 1'b1, mac_rst: 1'b1, ready: 1'b0};
         ST_RUN:    o = '{phy_reset_n: 1'b1, mac_rst: 1'b0, ready: 1'b1};
         default:   o = SEQ_OUT_RESET;
      endcase
      return o;
   endfunction

endpackage
`default_nettype wire

// File: rtl/phy_reset_ctrl_sync.sv
`default_nettype none
// ============================================================================
//  Module      : phy_reset_ctrl_sync
//  Description : N-stage flop synchroniser with a programmable reset value,
//                so an active-low input is not falsely seen after reset.
//  Ports       : clk    - clock
//                rst_n  - synchronous active-low reset (loads INIT)
//                d_i    - asynchronous input
//                q_o    - synchronised output
//  Revision    : 1.0  initial release
// ============================================================================
module phy_reset_ctrl_sync #(
   parameter int               WIDTH = 1,
   parameter int               N     = 2,
   parameter logic [WIDTH-1:0] INIT  = '1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [N-1:0][WIDTH-1:0] stage_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stage_q <= {N{INIT}};
      end else begin
         stage_q <= {stage_q[N-2:0], d_i};
      end
   end

   assign q_o = stage_q[N-1];

endmodule
`default_nettype wire

// File: rtl/phy_reset_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : phy_reset_ctrl
//  Description : Timed, re-triggerable reset sequencer for one external PHY.
//                Holds the PHY in reset for ASSERT_CYCLES, waits SETTLE_CYCLES,
//                then releases the MAC/core. Also latches the PHY interrupt.
//  Ports       : clk          - system clock
//                rst_n        - synchronous active-low reset
//                req          - single-cycle request to re-run the sequence
//                phy_reset_n  - registered active-low reset to the PHY
//                mac_rst      - registered active-high MAC/core reset
//                ready        - sequence complete (RUN)
//                phy_int_n    - asynchronous active-low PHY interrupt
//                int_pending  - sticky interrupt flag
//                int_ack      - single-cycle clear of int_pending
//                reset_count  - number of req-initiated resets, saturating
//  Revision    : 1.0  initial release
// ============================================================================
module phy_reset_ctrl
   import phy_reset_ctrl_pkg::*;
#(
   parameter int ASSERT_CYCLES = 1250000,
   parameter int SETTLE_CYCLES = 6250000,
   parameter int SYNC_STAGES   = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req,
   output logic       phy_reset_n,
   output logic       mac_rst,
   output logic       ready,
   input  logic       phy_int_n,
   output logic       int_pending,
   input  logic       int_ack,
   output logic [7:0] reset_count
);

   localparam int CNT_MAX = (ASSERT_CYCLES > SETTLE_CYCLES) ? ASSERT_CYCLES : SETTLE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(ASSERT_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   seq_out_t         out_q, out_d;
   logic [7:0]       reset_count_q;
   logic             int_pending_q;
   logic             int_sync;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_ASSERT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic. A request overrides any terminal-count move so a
   // request landing on the last SETTLE cycle still restarts the sequence.
   // The counter only runs in ASSERT/SETTLE and is parked at zero in RUN.
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (req) begin
         state_d = ST_ASSERT;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_ASSERT: begin
               if (cnt_q == ASSERT_LAST) begin
                  state_d = ST_SETTLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            ST_SETTLE: begin
               if (cnt_q == SETTLE_LAST) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            ST_RUN: begin
               cnt_d = '0;
            end
            default: begin
               state_d = ST_ASSERT;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Output logic: decoded from the next state and registered, so the
   // pins track state_q exactly and never glitch.
   // ------------------------------------------------------------------
   always_comb begin
      out_d = state_outputs(state_d);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q <= SEQ_OUT_RESET;
      end else begin
         out_q <= out_d;
      end
   end

   // ------------------------------------------------------------------
   // Interrupt synchroniser; idles high so reset never looks like an IRQ.
   // ------------------------------------------------------------------
   phy_reset_ctrl_sync #(
      .WIDTH (1),
      .N     (SYNC_STAGES),
      .INIT  (1'b1)
   ) u_int_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (phy_int_n),
      .q_o   (int_sync)
   );

   // Request counter and sticky interrupt flag. A request clears the flag
   // outright; otherwise a level set in RUN beats a same-cycle ack.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         reset_count_q <= 8'd0;
         int_pending_q <= 1'b0;
      end else begin
         if (req && (reset_count_q != 8'hFF)) begin
            reset_count_q <= reset_count_q + 8'd1;
         end
         if (req) begin
            int_pending_q <= 1'b0;
         end else if ((state_q == ST_RUN) && !int_sync) begin
            int_pending_q <= 1'b1;
         end else if (int_ack) begin
            int_pending_q <= 1'b0;
         end
      end
   end

   assign phy_reset_n = out_q.phy_reset_n;
   assign mac_rst     = out_q.mac_rst;
   assign ready       = out_q.ready;
   assign int_pending = int_pending_q;
   assign reset_count = reset_count_q;

endmodule
`default_nettype wire

// File: tb/tb_phy_reset_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phy_reset_ctrl
//  Description : Directed self-checking bench for phy_reset_ctrl with
//                ASSERT_CYCLES=4, SETTLE_CYCLES=6, SYNC_STAGES=2.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_phy_reset_ctrl;

   localparam int A = 4;
   localparam int S = 6;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req;
   logic       phy_reset_n;
   logic       mac_rst;
   logic       ready;
   logic       phy_int_n;
   logic       int_pending;
   logic       int_ack;
   logic [7:0] reset_count;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

   phy_reset_ctrl #(
      .ASSERT_CYCLES (A),
      .SETTLE_CYCLES (S),
      .SYNC_STAGES   (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .phy_reset_n (phy_reset_n),
      .mac_rst     (mac_rst),
      .ready       (ready),
      .phy_int_n   (phy_int_n),
      .int_pending (int_pending),
      .int_ack     (int_ack),
      .reset_count (reset_count)
   );

   always #5 clk = ~clk;

   // Advance one clock and sample 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req = 1'b0; phy_int_n = 1'b1; int_ack = 1'b0;
      tick(); tick();
      checks++;
      if ({phy_reset_n, mac_rst, ready, int_pending, reset_count} !== {1'b0, 1'b1, 1'b0, 1'b0, 8'd0}) begin
         errors++;
         $display("FAIL reset_values: got prn=%b mac=%b rdy=%b ip=%b cnt=%0d, want 0 1 0 0 0",
                  phy_reset_n, mac_rst, ready, int_pending, reset_count);
      end
      rst_n = 1'b1;
      for (int k = 0; k <= 13; k++) begin
         checks++;
         if ({phy_reset_n, mac_rst, ready} !== {(k >= A), (k < A + S), (k >= A + S)}) begin
            errors++;
            $display("FAIL release_seq cycle %0d: got prn=%b mac=%b rdy=%b, want %b %b %b",
                     k, phy_reset_n, mac_rst, ready, (k >= A), (k < A + S), (k >= A + S));
         end
         tick();
      end
   endtask

   task automatic test_req_run();
      req = 1'b1; tick(); req = 1'b0;
      for (int k = 0; k <= 10; k++) begin
         checks++;
         if ({phy_reset_n, mac_rst, ready} !== {(k >= A), (k < A + S), (k >= A + S)}) begin
            errors++;
            $display("FAIL req_seq cycle %0d: got prn=%b mac=%b rdy=%b, want %b %b %b",
                     k, phy_reset_n, mac_rst, ready, (k >= A), (k < A + S), (k >= A + S));
         end
         tick();
      end
      checks++;
      if (reset_count !== 8'd1) begin
         errors++;
         $display("FAIL req_count: got %0d, want 1", reset_count);
      end
   endtask

   task automatic test_saturation();
      exp_cnt = 1;
      req = 1'b1;
      for (int i = 0; i < 299; i++) begin
         tick();
         exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
         checks++;
         if (reset_count !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL sat_count req %0d: got %0d, want %0d", i + 2, reset_count, exp_cnt);
         end
      end
      req = 1'b0;
      for (int k = 0; k < A + S; k++) tick();
      checks++;
      if ({ready, reset_count} !== {1'b1, 8'd255}) begin
         errors++;
         $display("FAIL sat_final: got rdy=%b cnt=%0d, want 1 255", ready, reset_count);
      end
   endtask

   task automatic test_retrigger();
      req = 1'b1; tick(); req = 1'b0;
      tick(); tick();
      checks++;
      if (phy_reset_n !== 1'b0) begin
         errors++;
         $display("FAIL retrig_pre: got prn=%b, want 0", phy_reset_n);
      end
      req = 1'b1; tick(); req = 1'b0;
      for (int k = 0; k <= 10; k++) begin
         checks++;
         if ({phy_reset_n, ready} !== {(k >= A), (k >= A + S)}) begin
            errors++;
            $display("FAIL retrig_seq cycle %0d: got prn=%b rdy=%b, want %b %b",
                     k, phy_reset_n, ready, (k >= A), (k >= A + S));
         end
         tick();
      end
      checks++;
      if (reset_count !== 8'd255) begin
         errors++;
         $display("FAIL retrig_count: got %0d, want 255", reset_count);
      end
   endtask

   task automatic test_req_at_settle_tc();
      req = 1'b1; tick(); req = 1'b0;
      for (int k = 0; k < A + S - 1; k++) tick();
      checks++;
      if ({phy_reset_n, ready} !== 2'b10) begin
         errors++;
         $display("FAIL settle_last: got prn=%b rdy=%b, want 1 0", phy_reset_n, ready);
      end
      req = 1'b1; tick(); req = 1'b0;
      checks++;
      if ({phy_reset_n, mac_rst, ready} !== 3'b010) begin
         errors++;
         $display("FAIL settle_tc_req: got prn=%b mac=%b rdy=%b, want 0 1 0", phy_reset_n, mac_rst, ready);
      end
      for (int k = 0; k < A + S; k++) tick();
      checks++;
      if (ready !== 1'b1) begin
         errors++;
         $display("FAIL settle_tc_rerun: got rdy=%b, want 1", ready);
      end
   endtask

   task automatic test_int_latch();
      phy_int_n = 1'b0; tick(); phy_int_n = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         checks++;
         if (int_pending !== (k >= 3)) begin
            errors++;
            $display("FAIL int_latency cycle +%0d: got %b, want %b", k, int_pending, (k >= 3));
         end
         tick();
      end
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      checks++;
      if (int_pending !== 1'b0) begin
         errors++;
         $display("FAIL int_ack_clear: got %b, want 0", int_pending);
      end
      phy_int_n = 1'b0; int_ack = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k >= 3) begin
            checks++;
            if (int_pending !== 1'b1) begin
               errors++;
               $display("FAIL int_set_wins cycle +%0d: got %b, want 1", k, int_pending);
            end
         end
      end
      phy_int_n = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      int_ack = 1'b0;
      checks++;
      if (int_pending !== 1'b0) begin
         errors++;
         $display("FAIL int_release_ack: got %b, want 0", int_pending);
      end
   endtask

   task automatic test_int_ignored_settle();
      req = 1'b1; tick(); req = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      for (int k = 5; k <= 13; k++) begin
         phy_int_n = (k >= 5 && k <= 7) ? 1'b0 : 1'b1;
         checks++;
         if (int_pending !== 1'b0) begin
            errors++;
            $display("FAIL int_settle_ignored cycle %0d: got %b, want 0", k, int_pending);
         end
         tick();
      end
      phy_int_n = 1'b1;
   endtask

   task automatic test_req_clears_int();
      phy_int_n = 1'b0; tick(); phy_int_n = 1'b1;
      tick(); tick();
      checks++;
      if (int_pending !== 1'b1) begin
         errors++;
         $display("FAIL int_before_req: got %b, want 1", int_pending);
      end
      req = 1'b1; tick(); req = 1'b0;
      checks++;
      if (int_pending !== 1'b0) begin
         errors++;
         $display("FAIL req_clears_int: got %b, want 0", int_pending);
      end
      for (int k = 0; k < A + S; k++) tick();
   endtask

   task automatic test_rst_mid();
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      req = 1'b1; tick(); tick(); tick(); req = 1'b0;
      checks++;
      if (reset_count !== 8'd3) begin
         errors++;
         $display("FAIL rst_mid_pre_count: got %0d, want 3", reset_count);
      end
      for (int k = 0; k < 5; k++) tick();
      checks++;
      if ({phy_reset_n, mac_rst, ready} !== 3'b110) begin
         errors++;
         $display("FAIL rst_mid_in_settle: got prn=%b mac=%b rdy=%b, want 1 1 0", phy_reset_n, mac_rst, ready);
      end
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      checks++;
      if ({phy_reset_n, mac_rst, ready, int_pending, reset_count} !== {1'b0, 1'b1, 1'b0, 1'b0, 8'd0}) begin
         errors++;
         $display("FAIL rst_mid_values: got prn=%b mac=%b rdy=%b ip=%b cnt=%0d, want 0 1 0 0 0",
                  phy_reset_n, mac_rst, ready, int_pending, reset_count);
      end
      for (int k = 0; k <= 10; k++) begin
         checks++;
         if ({phy_reset_n, mac_rst, ready} !== {(k >= A), (k < A + S), (k >= A + S)}) begin
            errors++;
            $display("FAIL rst_mid_seq cycle %0d: got prn=%b mac=%b rdy=%b, want %b %b %b",
                     k, phy_reset_n, mac_rst, ready, (k >= A), (k < A + S), (k >= A + S));
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_req_run();
      test_saturation();
      test_retrigger();
      test_req_at_settle_tc();
      test_int_latch();
      test_int_ignored_settle();
      test_req_clears_int();
      test_rst_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
